// File: rtl/midi_note_decoder.sv
// MIDI Note On/Off decoder with running status for one channel (or omni).
// Produces a monophonic last-note-wins note register, velocity and change strobe.
module midi_note_decoder #(
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic [7:0] note_value,
  output logic       note_on_out,
  output logic [6:0] velocity_out,
  output logic       note_strobe_out
);

  localparam logic [3:0] LP_CHANNEL = 4'(CHANNEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_status;
  logic [6:0] r_key;

  // Completed-message event, applied to the outputs one cycle later.
  logic       r_evt_valid;
  logic       r_evt_on;
  logic [6:0] r_evt_key;
  logic [6:0] r_evt_vel;

  logic       w_is_realtime;
  logic       w_is_system;
  logic       w_is_channel;
  logic       w_one_byte;
  logic       w_accept;
  logic       w_complete;
  logic [7:0] w_next_note;
  logic       w_next_on;
  logic [6:0] w_next_vel;

  assign w_is_realtime = (byte_in[7:3] == 5'b11111);
  assign w_is_system   = (byte_in[7:3] == 5'b11110);
  assign w_is_channel  = byte_in[7] && (byte_in[7:4] != 4'hF);
  assign w_one_byte    = (r_status[7:5] == 3'b110);
  assign w_accept      = ((OMNI != 0) || (r_status[3:0] == LP_CHANNEL)) &&
                         (r_status[7:5] == 3'b100);
  // Only 2-byte messages can be accepted, so completion happens solely in DATA2.
  assign w_complete    = byte_valid_in && !byte_in[7] && (r_state == DATA2) && w_accept;

  always_comb begin
    w_next_note = note_value;
    w_next_on   = note_on_out;
    w_next_vel  = velocity_out;
    if (r_evt_valid) begin
      if (r_evt_on) begin
        w_next_note = {1'b0, r_evt_key};
        w_next_on   = 1'b1;
        w_next_vel  = r_evt_vel;
      end else if (note_on_out && ({1'b0, r_evt_key} == note_value)) begin
        w_next_note = 8'd0;
        w_next_on   = 1'b0;
        w_next_vel  = 7'd0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state         <= IDLE;
      r_status        <= 8'd0;
      r_key           <= 7'd0;
      r_evt_valid     <= 1'b0;
      r_evt_on        <= 1'b0;
      r_evt_key       <= 7'd0;
      r_evt_vel       <= 7'd0;
      note_value      <= 8'd0;
      note_on_out     <= 1'b0;
      velocity_out    <= 7'd0;
      note_strobe_out <= 1'b0;
    end else begin
      r_evt_valid <= w_complete;
      r_evt_on    <= r_status[4] && (byte_in[6:0] != 7'd0);
      r_evt_key   <= r_key;
      r_evt_vel   <= byte_in[6:0];

      note_value      <= w_next_note;
      note_on_out     <= w_next_on;
      velocity_out    <= w_next_vel;
      note_strobe_out <= (w_next_note != note_value) || (w_next_on != note_on_out) ||
                         (w_next_vel != velocity_out);

      if (byte_valid_in && !w_is_realtime) begin
        if (w_is_system) begin
          r_state  <= IDLE;
          r_status <= 8'd0;
        end else if (w_is_channel) begin
          r_state  <= DATA1;
          r_status <= byte_in;
        end else begin
          case (r_state)
            DATA1: begin
              if (!w_one_byte) begin
                r_key   <= byte_in[6:0];
                r_state <= DATA2;
              end
            end
            DATA2:   r_state <= DATA1;
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
